// File: rtl/updown_digit_counter.sv
// updown_digit_counter
//   Multi-digit up/down counter driven by two push-button levels. Each button is
//   synchronised through three flops and rising-edge detected, so one press is
//   one step. Digits are held base-BASE in 4-bit nibbles with carry/borrow
//   rippling digit to digit; the range ends either wrap or saturate.
//
// Parameters
//   DIGITS   number of digits (1..4)
//   BASE     radix per digit (2..16)
//   SATURATE 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   clk_plus   system clock, rising edge
//   reset      asynchronous active-low reset
//   inc_in     asynchronous button level, rising edge requests +1
//   dec_in     asynchronous button level, rising edge requests -1
//   load       synchronous load strobe (wins over any step)
//   load_val   digit-packed load value, digit 0 in [3:0]
//   count      digit-packed count, digit 0 least significant
//   at_max     all digits at BASE-1 (from count only)
//   at_min     all digits at 0 (from count only)
//   overflow   one-cycle pulse: increment requested while at_max
//   underflow  one-cycle pulse: decrement requested while at_min
module updown_digit_counter #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned BASE     = 10,
    parameter int unsigned SATURATE = 0
) (
    input  logic                clk_plus,
    input  logic                reset,
    input  logic                inc_in,
    input  logic                dec_in,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                at_max,
    output logic                at_min,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [3:0] MaxDigit = 4'(BASE - 1);
    localparam logic [4:0] BaseW    = 5'(BASE);
    localparam bit         SatMode  = (SATURATE != 0);

    // Bit 0 is the first synchroniser flop, bit 2 the edge-detect history flop.
    logic [2:0] inc_sync_q, dec_sync_q;
    logic       up, dn;

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic [4*DIGITS-1:0] inc_val, dec_val, load_fix;

    always_ff @(posedge clk_plus or negedge reset) begin
        if (!reset) begin
            inc_sync_q  <= '0;
            dec_sync_q  <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            inc_sync_q  <= {inc_sync_q[1:0], inc_in};
            dec_sync_q  <= {dec_sync_q[1:0], dec_in};
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign up = inc_sync_q[1] & ~inc_sync_q[2];
    assign dn = dec_sync_q[1] & ~dec_sync_q[2];

    always_comb begin
        at_max = 1'b1;
        at_min = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (count_q[4*i +: 4] != MaxDigit) at_max = 1'b0;
            if (count_q[4*i +: 4] != 4'd0)     at_min = 1'b0;
        end
    end

    // Increment ripple: at all-max the carry runs off the top and leaves all zeros.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        inc_val = count_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == MaxDigit) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Decrement ripple: at all-zero the borrow runs off the top and leaves all max.
    always_comb begin
        logic borrow;
        borrow  = 1'b1;
        dec_val = count_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = MaxDigit;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Out-of-range load digits are forced to 0 so a digit never leaves 0..BASE-1.
    always_comb begin
        load_fix = load_val;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if ({1'b0, load_val[4*i +: 4]} >= BaseW) load_fix[4*i +: 4] = 4'd0;
        end
    end

    always_comb begin
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (load) begin
            count_d = load_fix;
        end else if (up && !dn) begin
            overflow_d = at_max;
            if (!(at_max && SatMode)) count_d = inc_val;
        end else if (dn && !up) begin
            underflow_d = at_min;
            if (!(at_min && SatMode)) count_d = dec_val;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_updown_digit_counter.sv
// Bench for updown_digit_counter. Three instances share one stimulus stream:
//   a: DIGITS=2 BASE=10 SATURATE=0
//   b: DIGITS=2 BASE=10 SATURATE=1
//   c: DIGITS=3 BASE=16 SATURATE=0
// A value-level model (count as an integer modulo BASE**DIGITS) is compared
// every cycle; directed sections add literal expectations.
module tb_updown_digit_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inc, dec, load;
    logic [11:0] load_val;

    logic [7:0]  count_a, count_b;
    logic [11:0] count_c;
    logic        max_a, max_b, max_c, min_a, min_b, min_c;
    logic        ovf_a, ovf_b, ovf_c, unf_a, unf_b, unf_c;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    updown_digit_counter #(.DIGITS(2), .BASE(10), .SATURATE(0)) dut_a (
        .clk_plus(clk), .reset(rst_n), .inc_in(inc), .dec_in(dec), .load(load),
        .load_val(load_val[7:0]), .count(count_a), .at_max(max_a), .at_min(min_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    updown_digit_counter #(.DIGITS(2), .BASE(10), .SATURATE(1)) dut_b (
        .clk_plus(clk), .reset(rst_n), .inc_in(inc), .dec_in(dec), .load(load),
        .load_val(load_val[7:0]), .count(count_b), .at_max(max_b), .at_min(min_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    updown_digit_counter #(.DIGITS(3), .BASE(16), .SATURATE(0)) dut_c (
        .clk_plus(clk), .reset(rst_n), .inc_in(inc), .dec_in(dec), .load(load),
        .load_val(load_val), .count(count_c), .at_max(max_c), .at_min(min_c),
        .overflow(ovf_c), .underflow(unf_c)
    );

    logic [15:0] dcount [3];
    logic [2:0]  dmax, dmin, dovf, dunf;
    assign dcount[0] = {8'h00, count_a};
    assign dcount[1] = {8'h00, count_b};
    assign dcount[2] = {4'h0, count_c};
    assign dmax = {max_c, max_b, max_a};
    assign dmin = {min_c, min_b, min_a};
    assign dovf = {ovf_c, ovf_b, ovf_a};
    assign dunf = {unf_c, unf_b, unf_a};

    int unsigned cfg_digits [3] = '{2, 2, 3};
    int unsigned cfg_base   [3] = '{10, 10, 16};
    bit          cfg_sat    [3] = '{1'b0, 1'b1, 1'b0};

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int unsigned ipow(input int unsigned b, input int unsigned e);
        int unsigned r = 1;
        for (int k = 0; k < int'(e); k++) r = r * b;
        return r;
    endfunction

    // Value of a packed load word, out-of-range digits read as 0.
    function automatic int unsigned load_value(input logic [15:0] p, input int unsigned nd,
                                               input int unsigned b);
        int unsigned v = 0;
        for (int d = int'(nd) - 1; d >= 0; d--) begin
            logic [15:0] t;
            int unsigned dig;
            t   = p >> (4 * d);
            dig = int'(t[3:0]);
            v   = v * b + ((dig < b) ? dig : 0);
        end
        return v;
    endfunction

    function automatic int unsigned to_packed(input int unsigned v, input int unsigned nd,
                                              input int unsigned b);
        int unsigned p = 0;
        int unsigned r = v;
        for (int d = 0; d < int'(nd); d++) begin
            p = p | ((r % b) << (4 * d));
            r = r / b;
        end
        return p;
    endfunction

    // Model: a press takes effect on the second edge after the edge that first sees it high.
    int unsigned mval [3];
    bit          movf [3];
    bit          munf [3];
    bit          inc_seen [3];
    bit          dec_seen [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mval[i] = 0; movf[i] = 0; munf[i] = 0;
                inc_seen[i] = 0; dec_seen[i] = 0;
            end
        end else begin
            bit want_up, want_dn;
            want_up = inc_seen[1] && !inc_seen[2];
            want_dn = dec_seen[1] && !dec_seen[2];
            for (int i = 0; i < 3; i++) begin
                int unsigned top;
                top     = ipow(cfg_base[i], cfg_digits[i]) - 1;
                movf[i] = 0;
                munf[i] = 0;
                if (load) begin
                    mval[i] = load_value({4'h0, load_val}, cfg_digits[i], cfg_base[i]);
                end else if (want_up && !want_dn) begin
                    if (mval[i] == top) begin
                        movf[i] = 1;
                        if (!cfg_sat[i]) mval[i] = 0;
                    end else begin
                        mval[i] = mval[i] + 1;
                    end
                end else if (want_dn && !want_up) begin
                    if (mval[i] == 0) begin
                        munf[i] = 1;
                        if (!cfg_sat[i]) mval[i] = top;
                    end else begin
                        mval[i] = mval[i] - 1;
                    end
                end
            end
            inc_seen[2] = inc_seen[1]; inc_seen[1] = inc_seen[0]; inc_seen[0] = inc;
            dec_seen[2] = dec_seen[1]; dec_seen[1] = dec_seen[0]; dec_seen[0] = dec;
        end
    end

    int ovf_seen [3] = '{0, 0, 0};
    int unf_seen [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int unsigned top;
            top = ipow(cfg_base[i], cfg_digits[i]) - 1;
            check($sformatf("count[%0d]", i), dcount[i], to_packed(mval[i], cfg_digits[i],
                  cfg_base[i]));
            check($sformatf("at_max[%0d]", i), dmax[i], (mval[i] == top) ? 1 : 0);
            check($sformatf("at_min[%0d]", i), dmin[i], (mval[i] == 0) ? 1 : 0);
            check($sformatf("overflow[%0d]", i), dovf[i], movf[i]);
            check($sformatf("underflow[%0d]", i), dunf[i], munf[i]);
            ovf_seen[i] += int'(dovf[i]);
            unf_seen[i] += int'(dunf[i]);
        end
    end

    // Inputs change 2 ns after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input bit up_btn, input bit dn_btn);
        inc = up_btn; dec = dn_btn;
        step(2);
        inc = 1'b0; dec = 1'b0;
        step(3);
    endtask

    task automatic do_load(input logic [11:0] v);
        load = 1'b1; load_val = v;
        step(1);
        load = 1'b0;
        step(1);
    endtask

    initial begin
        int o0, u0, o1, u1;
        rst_n = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0; load_val = '0;
        step(2);
        check("reset count_a", count_a, 0);
        check("reset at_min_a", min_a, 1);
        check("reset at_max_a", max_a, 0);
        rst_n = 1'b1;
        step(2);

        // First press with explicit latency, then 11 more.
        o0 = ovf_seen[0];
        inc = 1'b1;
        step(1);                       // edge N: s1 sees it
        step(1);                       // edge N+1
        check("latency N+1 count_a", count_a, 8'h00);
        step(1);                       // edge N+2: step applied
        check("latency N+2 count_a", count_a, 8'h01);
        inc = 1'b0;
        step(2);
        repeat (11) press(1'b1, 1'b0);
        check("12 inc count_a", count_a, 8'h12);
        check("12 inc count_c", count_c, 12'h00C);
        check("12 inc no overflow", ovf_seen[0] - o0, 0);

        // Wrap at both ends.
        do_load(12'h099);
        o0 = ovf_seen[0]; u0 = unf_seen[0];
        press(1'b1, 1'b0);
        check("wrap inc count_a", count_a, 8'h00);
        check("wrap inc at_min_a", min_a, 1);
        check("wrap inc overflow pulses", ovf_seen[0] - o0, 1);
        press(1'b0, 1'b1);
        check("wrap dec count_a", count_a, 8'h99);
        check("wrap dec at_max_a", max_a, 1);
        check("wrap dec underflow pulses", unf_seen[0] - u0, 1);

        // Saturation on instance b.
        do_load(12'h000);
        u1 = unf_seen[1];
        repeat (3) press(1'b0, 1'b1);
        check("sat dec count_b", count_b, 8'h00);
        check("sat underflow pulses", unf_seen[1] - u1, 3);
        do_load(12'h099);
        o1 = ovf_seen[1];
        press(1'b1, 1'b0);
        check("sat inc count_b", count_b, 8'h99);
        check("sat overflow pulses", ovf_seen[1] - o1, 1);

        // Simultaneous up and down cancel.
        do_load(12'h045);
        o0 = ovf_seen[0]; u0 = unf_seen[0];
        press(1'b1, 1'b1);
        check("both count_a", count_a, 8'h45);

        // Load in the step cycle wins; digit C is out of range for base 10.
        inc = 1'b1;
        step(2);
        load = 1'b1; load_val = 12'h03C;
        step(1);
        load = 1'b0; inc = 1'b0;
        step(3);
        check("load wins count_a", count_a, 8'h30);
        check("load wins count_c", count_c, 12'h03C);
        check("no pulses a", (ovf_seen[0] - o0) + (unf_seen[0] - u0), 0);

        // Base-16 carry/borrow across digits.
        do_load(12'h0FF);
        press(1'b1, 1'b0);
        check("hex inc count_c", count_c, 12'h100);
        press(1'b0, 1'b1);
        check("hex dec count_c", count_c, 12'h0FF);

        // Button held through reset release gives exactly one step.
        do_load(12'h007);
        check("pre-reset count_a", count_a, 8'h07);
        rst_n = 1'b0;
        inc = 1'b1;
        #1;
        check("in reset count_a", count_a, 8'h00);
        step(3);
        rst_n = 1'b1;
        step(2);
        check("release+2 count_a", count_a, 8'h00);
        step(1);
        check("release+3 count_a", count_a, 8'h01);
        step(6);
        check("held count_a", count_a, 8'h01);
        inc = 1'b0;
        step(3);

        // Random phase.
        for (int n = 0; n < 3000; n++) begin
            inc  = 1'($urandom_range(0, 1));
            dec  = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 5))
                0:       load_val = 12'h000;
                1:       load_val = 12'h999;
                2:       load_val = 12'hFFF;
                default: load_val = 12'($urandom);
            endcase
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            step(1);
            rst_n = 1'b1;
        end
        inc = 1'b0; dec = 1'b0; load = 1'b0;
        step(4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
